count_down_timer: RTL and testbench
===================================

# count_down_timer

Loadable down-counting timer, the complement of the 4-bit up counter `Count`. It loads a start value, decrements once per prescaled tick, and pulses `done` when the count expires. It optionally auto-reloads for periodic operation. It sits beside `Count` in the timing/sequencing logic and supplies timeouts and periodic strobes to control FSMs.

## Interface
- `WIDTH`, 4: width of the count and load value; must be ≥ 2.
- `PRESCALE`, 1: clk cycles per decrement; must be ≥ 1. Prescaler counter width is clog2(PRESCALE), minimum 1.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: load `load_val` and begin counting; accepted in any state.
- `load_val` input WIDTH: start value, sampled on the cycle `start` is high.
- `auto_reload` input 1: periodic mode, sampled together with `start`.
- `pause` input 1: level; freezes the count and prescaler while high.
- `abort` input 1: return to IDLE immediately without asserting `done`.
- `cnt` output WIDTH: current count, registered.
- `busy` output 1: high whenever state ≠ IDLE, registered.
- `done` output 1: one-cycle expiry pulse, registered.

## Operation
- **States:** IDLE, RUN, PAUSED. Internal registers are `reload_q` (WIDTH bits), `auto_q`, and the prescaler `pre`.
- **Priority per edge:** rst > abort > start > pause > count.
- **rst:** state = IDLE, `cnt` = 0, `busy` = 0, `done` = 0, `pre` = 0, `reload_q` = 0, `auto_q` = 0.
- **abort:** from any state, go to IDLE with `cnt` = 0, `pre` = 0, `done` = 0, `busy` = 0.
- **start with `load_val` ≠ 0:** from any state, restart.
  - `cnt` = `load_val`, `reload_q` = `load_val`, `auto_q` = `auto_reload`, `pre` = 0.
  - State = RUN, or PAUSED if `pause` is also high.
  - Restart in RUN or PAUSED never produces `done` for the abandoned count.
- **start with `load_val` = 0:** `done` pulses on the next edge, state = IDLE, `cnt` = 0, `busy` stays 0.
- **RUN, no pause:**
  - If `pre` = PRESCALE−1, a tick occurs: `pre` wraps to 0. Otherwise `pre` increments.
  - On a tick with `cnt` > 1: `cnt` decrements by 1.
  - On a tick with `cnt` = 1: `done` = 1.
    - If `auto_q` = 1: `cnt` = `reload_q` and the state stays RUN.
    - If `auto_q` = 0: `cnt` = 0 and state = IDLE.
- **RUN with pause = 1:** go to PAUSED. `cnt` and `pre` hold; `busy` stays 1.
- **PAUSED with pause = 0:** go to RUN and resume from the held `pre` and `cnt`.
- **IDLE:** `cnt` holds its value, `done` = 0, `pause` is ignored.
- **Arithmetic:**
  - Unsigned throughout.
  - `cnt` never wraps below 0; underflow is impossible by construction.
  - `done` is never high for two consecutive cycles, except in auto-reload with `reload_q` = 1 and PRESCALE = 1, where it is high every cycle.

## Timing
- `start` sampled at edge E0 gives `cnt` = L and `busy` = 1 visible after E0.
- First decrement occurs at edge E0 + PRESCALE.
- `done` is high for exactly the cycle after edge E0 + L·PRESCALE, in the same cycle `cnt` shows 0, or shows the reload value in auto mode.
- `busy` falls in the same cycle `done` rises (non-auto mode).
- Each cycle spent in PAUSED extends expiry by exactly one cycle.
- `abort` or `rst` take effect on the edge they are sampled. Outputs reflect the reset values in the following cycle.
- Output latency from inputs is one cycle; no combinational path from input to output.

## Test plan
- **Reset mid-count, WIDTH=4, PRESCALE=1:** start with `load_val`=5, assert `rst` after 2 edges → `cnt`=0, `busy`=0, `done`=0 next cycle, and no `done` afterwards.
- **Basic expiry:** start with `load_val`=5 at E0 → `cnt` reads 5,4,3,2,1,0 after E0..E5. `done` is high only after E5, and `busy` falls at the same time.
- **Prescale:** PRESCALE=3, `load_val`=4 → each `cnt` value is held for 3 cycles, and `done` rises after edge E0+12.
- **Auto-reload:** `load_val`=3, `auto_reload`=1 → `done` pulses every 3 cycles, `cnt` cycles 3,2,1,3,2,1…, and `busy` stays 1. `abort` then gives IDLE with `cnt`=0 and no `done`.
- **Pause and restart:** `load_val`=6, hold `pause` for 4 cycles at `cnt`=4 → `done` arrives 4 cycles later than without pause. Then restart with `start` and `load_val`=2 at `cnt`=3 → `cnt`=2, `done` 2 cycles later, and no `done` from the abandoned count.
- **Zero load and priority:** start with `load_val`=0 → a one-cycle `done` with `busy`=0. `abort` and `start` asserted together → IDLE, `cnt`=0.

Source files
------------

// File: rtl/count_down_timer_if.sv
// count_down_timer_if: control and status bundle for count_down_timer.
interface count_down_timer_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;
  modport master(output start, load_val, auto_reload, pause, abort, input cnt, busy, done);
  modport slave(input start, load_val, auto_reload, pause, abort, output cnt, busy, done);
endinterface

// File: rtl/count_down_timer.sv
// count_down_timer: loadable prescaled down-counter with expiry pulse and optional auto-reload.
module count_down_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input logic               clk,
  input logic               rst,
  count_down_timer_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] cnt_q, reload_q;
  logic [PW-1:0]    pre_q;
  logic             auto_q, busy_q, done_q;
  logic             tick;
  assign tick     = pre_q == PW'(PRESCALE - 1);
  assign bus.cnt  = cnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  // Leaving PAUSED counts on the same edge, so each paused cycle costs exactly one cycle.
  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      pre_q    <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
    end else if (bus.abort) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      busy_q  <= 1'b0;
    end else if (bus.start) begin
      pre_q <= '0;
      if (bus.load_val == '0) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        state_q  <= bus.pause ? PAUSED : RUN;
        cnt_q    <= bus.load_val;
        reload_q <= bus.load_val;
        auto_q   <= bus.auto_reload;
        busy_q   <= 1'b1;
      end
    end else if (state_q != IDLE) begin
      if (bus.pause) begin
        state_q <= PAUSED;
      end else begin
        state_q <= RUN;
        pre_q   <= tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          if (cnt_q > WIDTH'(1)) begin
            cnt_q <= cnt_q - WIDTH'(1);
          end else begin
            done_q <= 1'b1;
            cnt_q  <= auto_q ? reload_q : '0;
            if (!auto_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_count_down_timer.sv
// tb_count_down_timer: drives a PRESCALE=1 and a PRESCALE=3 timer with shared stimulus against an elapsed-time model.
module tb_count_down_timer;
  logic clk = 0, rst = 0, start = 0, auto_reload = 0, pause = 0, abort = 0;
  logic [3:0] load_val = 0;
  int checks = 0, errors = 0;
  int P[2] = '{1, 3};
  bit m_act[2], m_auto[2], m_done[2];
  logic [3:0] m_cnt[2];
  int m_k[2], m_L[2];
  count_down_timer_if #(.WIDTH(4)) a ();
  count_down_timer_if #(.WIDTH(4)) b ();
  assign a.start = start;
  assign b.start = start;
  assign a.load_val = load_val;
  assign b.load_val = load_val;
  assign a.auto_reload = auto_reload;
  assign b.auto_reload = auto_reload;
  assign a.pause = pause;
  assign b.pause = pause;
  assign a.abort = abort;
  assign b.abort = abort;
  count_down_timer #(.WIDTH(4), .PRESCALE(1)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  count_down_timer #(.WIDTH(4), .PRESCALE(3)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  // Model: count shown is the load value minus whole prescale periods of running time elapsed.
  task automatic model(input int i);
    int per;
    if (rst || abort) begin
      m_act[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_auto[i] = rst ? 0 : m_auto[i];
    end else if (start) begin
      m_k[i] = 0;
      if (load_val == 0) begin
        m_act[i] = 0; m_cnt[i] = 0; m_done[i] = 1;
      end else begin
        m_act[i] = 1; m_L[i] = int'(load_val); m_auto[i] = auto_reload; m_cnt[i] = load_val; m_done[i] = 0;
      end
    end else if (m_act[i] && !pause) begin
      m_k[i]++;
      per = m_L[i] * P[i];
      m_done[i] = (m_k[i] % per) == 0;
      if (m_done[i] && !m_auto[i]) begin
        m_act[i] = 0; m_cnt[i] = 0;
      end else m_cnt[i] = 4'(m_L[i] - (m_k[i] % per) / P[i]);
    end else m_done[i] = 0;
  endtask
  task automatic step();
    model(0);
    model(1);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({a.cnt, a.busy, a.done, b.cnt, b.busy, b.done} !== 12'b0) begin
      errors++; $display("FAIL reset got %b exp 0", {a.cnt, a.busy, a.done, b.cnt, b.busy, b.done});
    end
    load_val = 5; start = 1;
    step();
    start = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    for (int n = 0; n < 8; n++) begin
      checks++;
      if ({a.cnt, a.busy, a.done} !== 6'b0) begin
        errors++; $display("FAIL reset_mid cyc %0d got %b exp 0", n, {a.cnt, a.busy, a.done});
      end
      step();
    end
  endtask
  task automatic test_basic();
    load_val = 5; start = 1;
    step();
    start = 0;
    for (int n = 0; n <= 5; n++) begin
      checks++;
      if ({a.cnt, a.busy, a.done} !== {4'(5 - n), n != 5, n == 5}) begin
        errors++; $display("FAIL basic edge %0d got %b exp %b", n, {a.cnt, a.busy, a.done}, {4'(5 - n), n != 5, n == 5});
      end
      checks++;
      if ({b.cnt, b.busy, b.done} !== {m_cnt[1], m_act[1], m_done[1]}) begin
        errors++; $display("FAIL basic_p3 edge %0d got %b exp %b", n, {b.cnt, b.busy, b.done}, {m_cnt[1], m_act[1], m_done[1]});
      end
      step();
    end
  endtask
  task automatic test_prescale();
    int at = -1;
    abort = 1; step(); abort = 0;
    load_val = 4; start = 1;
    step();
    start = 0;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (b.done && at < 0) at = n;
      checks++;
      if ({b.cnt, b.busy, b.done} !== {m_cnt[1], m_act[1], m_done[1]}) begin
        errors++; $display("FAIL prescale edge %0d got %b exp %b", n, {b.cnt, b.busy, b.done}, {m_cnt[1], m_act[1], m_done[1]});
      end
    end
    checks++;
    if (at !== 12) begin
      errors++; $display("FAIL prescale_done_edge got %0d exp 12", at);
    end
  endtask
  task automatic test_auto();
    load_val = 3; auto_reload = 1; start = 1;
    step();
    start = 0; auto_reload = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      checks++;
      if ({a.cnt, a.busy, a.done} !== {4'(3 - n % 3), 1'b1, n % 3 == 0}) begin
        errors++; $display("FAIL auto edge %0d got %b exp %b", n, {a.cnt, a.busy, a.done}, {4'(3 - n % 3), 1'b1, n % 3 == 0});
      end
    end
    abort = 1;
    step();
    abort = 0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({a.cnt, a.busy, a.done, b.cnt, b.busy, b.done} !== 12'b0) begin
        errors++; $display("FAIL auto_abort cyc %0d got %b exp 0", n, {a.cnt, a.busy, a.done, b.cnt, b.busy, b.done});
      end
      step();
    end
  endtask
  task automatic test_pause_restart();
    int at = -1, pulses = 0;
    load_val = 6; start = 1;
    step();
    start = 0;
    for (int n = 1; n <= 12; n++) begin
      pause = (n >= 3 && n <= 6);
      step();
      if (a.done && at < 0) at = n;
      checks++;
      if ({a.cnt, a.busy, a.done} !== {m_cnt[0], m_act[0], m_done[0]}) begin
        errors++; $display("FAIL pause edge %0d got %b exp %b", n, {a.cnt, a.busy, a.done}, {m_cnt[0], m_act[0], m_done[0]});
      end
    end
    pause = 0;
    checks++;
    if (at !== 10) begin
      errors++; $display("FAIL pause_done_edge got %0d exp 10", at);
    end
    load_val = 6; start = 1;
    step();
    start = 0;
    repeat (3) step();
    load_val = 2; start = 1;
    step();
    start = 0;
    checks++;
    if (a.cnt !== 4'd2) begin
      errors++; $display("FAIL restart_load got %0d exp 2", a.cnt);
    end
    for (int n = 1; n <= 6; n++) begin
      step();
      pulses += a.done;
      checks++;
      if (a.done !== (n == 2)) begin
        errors++; $display("FAIL restart_done edge %0d got %b exp %b", n, a.done, n == 2);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL restart_pulses got %0d exp 1", pulses);
    end
  endtask
  task automatic test_zero_priority();
    abort = 1; step(); abort = 0;
    load_val = 0; start = 1;
    step();
    start = 0;
    checks++;
    if ({a.cnt, a.busy, a.done, b.cnt, b.busy, b.done} !== 12'b0000_0_1_0000_0_1) begin
      errors++; $display("FAIL zero_load got %b exp 000001000001", {a.cnt, a.busy, a.done, b.cnt, b.busy, b.done});
    end
    step();
    checks++;
    if ({a.busy, a.done, b.done} !== 3'b0) begin
      errors++; $display("FAIL zero_load_after got %b exp 000", {a.busy, a.done, b.done});
    end
    load_val = 5; start = 1;
    step();
    load_val = 7; abort = 1;
    step();
    start = 0; abort = 0;
    checks++;
    if ({a.cnt, a.busy, a.done, b.cnt, b.busy, b.done} !== 12'b0) begin
      errors++; $display("FAIL abort_over_start got %b exp 0", {a.cnt, a.busy, a.done, b.cnt, b.busy, b.done});
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(99) < 2;
      abort = $urandom_range(99) < 3;
      start = $urandom_range(99) < 8;
      pause = $urandom_range(99) < 20;
      auto_reload = $urandom_range(1);
      load_val = ($urandom_range(9) == 0) ? 4'd0 : 4'($urandom_range(15));
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ((i == 0 ? {a.cnt, a.busy, a.done} : {b.cnt, b.busy, b.done}) !== {m_cnt[i], m_act[i], m_done[i]}) begin
          errors++;
          $display("FAIL random dut %0d cyc %0d got %b exp %b", i, n, (i == 0 ? {a.cnt, a.busy, a.done} : {b.cnt, b.busy, b.done}), {m_cnt[i], m_act[i], m_done[i]});
        end
      end
    end
    {rst, abort, start, pause, auto_reload} = '0;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_prescale();
    test_auto();
    test_pause_restart();
    test_zero_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
